vpi_toggle_checker: RTL and testbench

Self-checking consumer stage for the VPI scope regression designs. It samples the free-running toggle register and the generate-scope array lanes that the design under test produces. It verifies that the toggle inverts every cycle and that each registered lane equals its continuous lane delayed by one clock, then reports pass/fail so the test's initial block can end the run.

---
 rtl/vpi_toggle_checker.sv | 167 ++++++++++++++++
 tb/tb_vpi_toggle_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vpi_toggle_checker.sv
// rtl/vpi_toggle_checker.sv - self-checking consumer for VPI scope toggle/array designs
//
// Purpose: after a start request this block captures one sample (PRIME). It then
// compares every cycle (CHECK) that toggle_in has inverted and that each
// registered lane clk_in[k] (k>=1) equals cont_in[k] from the previous cycle.
// It stops in DONE with pass/err_code/count.
//
// Parameters:
//   NUM_CYCLES  passing compares required for pass (>=1)
//   WIDTH       array lanes; lane 0 is unregistered and never compared (>=2)
//
// Ports:
//   clk        clock, posedge
//   rst_n      asynchronous active-low reset
//   start      single-cycle run request
//   toggle_in  toggle register under test
//   cont_in    continuous-assign array lanes
//   clk_in     registered array lanes
//   busy       high in PRIME or CHECK
//   done       high in DONE
//   pass       result, valid while done
//   err_code   0 none, 1 toggle stuck, 2 pipeline mismatch, 3 start while busy
//   count      passing compares so far, frozen at failure
//
// Build option: define VPI_TOGGLE_CHECKER_PIPE_EN to compile in the lane
// pipeline compare. Without it the lane inputs are ignored and err_code 2 never occurs.

module vpi_toggle_checker #(
  parameter int NUM_CYCLES = 16,
  parameter int WIDTH      = 2,
  localparam int CW        = $clog2(NUM_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             toggle_in,
  input  logic [WIDTH-1:0] cont_in,
  input  logic [WIDTH-1:0] clk_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] COUNT_LAST = CW'(NUM_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_CYCLES);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TOG   = 2'd1;
  localparam logic [1:0] ERR_PIPE  = 2'd2;
  localparam logic [1:0] ERR_START = 2'd3;

  state_t        state, state_n;
  logic          pass_n;
  logic [1:0]    err_n;
  logic [CW-1:0] count_n;
  logic          prev_tog;
  logic          tog_bad;
  logic          pipe_bad;

  assign tog_bad = (toggle_in == prev_tog);

`ifdef VPI_TOGGLE_CHECKER_PIPE_EN
  logic [WIDTH-2:0] prev_cont;
  // Lane 0 has no register stage, so it is not part of the compare.
  logic unused_lane0;
  assign unused_lane0 = ^{cont_in[0], clk_in[0]};
  assign pipe_bad     = (clk_in[WIDTH-1:1] != prev_cont);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cont <= '0;
    end else if (state == S_PRIME || state == S_CHECK) begin
      prev_cont <= cont_in[WIDTH-1:1];
    end
  end
`else
  logic unused_lanes;
  assign unused_lanes = ^{cont_in, clk_in};
  assign pipe_bad     = 1'b0;
`endif

  // busy/done decode the state register directly, so they carry no input path.
  assign busy = (state == S_PRIME) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_comb begin
    state_n = state;
    pass_n  = pass;
    err_n   = err_code;
    count_n = count;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_PRIME;
          pass_n  = 1'b0;
          err_n   = ERR_NONE;
          count_n = '0;
        end
      end
      S_PRIME: begin
        if (start) begin
          state_n = S_DONE;
          pass_n  = 1'b0;
          err_n   = ERR_START;
        end else begin
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        // A re-start outranks any compare failure seen on the same edge.
        if (start) begin
          state_n = S_DONE;
          pass_n  = 1'b0;
          err_n   = ERR_START;
        end else if (tog_bad) begin
          state_n = S_DONE;
          pass_n  = 1'b0;
          err_n   = ERR_TOG;
        end else if (pipe_bad) begin
          state_n = S_DONE;
          pass_n  = 1'b0;
          err_n   = ERR_PIPE;
        end else begin
          if (count != COUNT_FULL) begin
            count_n = count + 1'b1;
          end
          if (count >= COUNT_LAST) begin
            state_n = S_DONE;
            pass_n  = 1'b1;
            err_n   = ERR_NONE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pass     <= 1'b0;
      err_code <= ERR_NONE;
      count    <= '0;
      prev_tog <= 1'b0;
    end else begin
      state    <= state_n;
      pass     <= pass_n;
      err_code <= err_n;
      count    <= count_n;
      if (state == S_PRIME || state == S_CHECK) begin
        prev_tog <= toggle_in;
      end
    end
  end

endmodule

// File: tb/tb_vpi_toggle_checker.sv
// tb/tb_vpi_toggle_checker.sv - scoreboard bench for vpi_toggle_checker

module tb_vpi_toggle_checker;
  localparam int NUM_CYCLES = 16;
  localparam int WIDTH      = 2;
  localparam int CW         = $clog2(NUM_CYCLES + 1);

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             start     = 1'b0;
  logic             toggle_in = 1'b0;
  logic [WIDTH-1:0] cont_in   = '0;
  logic [WIDTH-1:0] clk_in    = '0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       err_code;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int p;
    int e;
    int c;
  } res_t;
  res_t exp_q[$];

  logic [WIDTH-1:0] cont_hist = '0;
  logic             done_seen = 1'b0;

  vpi_toggle_checker #(.NUM_CYCLES(NUM_CYCLES), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .toggle_in (toggle_in),
    .cont_in   (cont_in),
    .clk_in    (clk_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_code  (err_code),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int e, input int c);
    res_t r;
    r.p = p;
    r.e = e;
    r.c = c;
    exp_q.push_back(r);
  endtask

  // Monitor: every rising edge of done is one reported result.
  always @(negedge clk) begin
    if (done && !done_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got pass=%0d err=%0d count=%0d expected no result",
                 pass, err_code, count);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("result_pass", int'(pass), r.p);
        chk("result_err", int'(err_code), r.e);
        chk("result_count", int'(count), r.c);
      end
    end
    done_seen <= done;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start     = 1'b0;
      toggle_in = ~toggle_in;
      clk_in    = cont_hist;
      cont_in   = WIDTH'($urandom);
      @(posedge clk);
      cont_hist = cont_in;
    end
  endtask

  // Edge k of the loop is run edge Ek; negative indices disable an option.
  task automatic run(input int stuck_at, input int pipe_at, input bit lane0_bad,
                     input int start2, input int start3, input int rst_at,
                     input int last, input bit tchk);
    toggle_in = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      start = (k == 0) || (k == start2) || (k == start3);
      if (k != stuck_at) toggle_in = ~toggle_in;
      clk_in[1] = cont_hist[1] ^ (k == pipe_at);
      clk_in[0] = lane0_bad ? ~cont_hist[0] : cont_hist[0];
      cont_in   = WIDTH'($urandom);
      @(posedge clk);
      cont_hist = cont_in;
      #1;
      if (tchk && k == 0) chk("busy_after_e0", int'(busy), 1);
      if (tchk && k == NUM_CYCLES) begin
        chk("busy_after_e16", int'(busy), 1);
        chk("done_after_e16", int'(done), 0);
      end
      if (tchk && k == NUM_CYCLES + 1) chk("busy_after_e17", int'(busy), 0);
      if (k == start3) begin
        chk("restart_busy", int'(busy), 1);
        chk("restart_count", int'(count), 0);
        chk("restart_err", int'(err_code), 0);
      end
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_err", int'(err_code), 0);
        chk("abort_count", int'(count), 0);
        break;
      end
    end
    if (rst_at >= 0) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    start = 1'b0;
    idle(3);
  endtask

  initial begin
    // Asynchronous reset in the middle of a clock phase.
    #12 rst_n = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_err", int'(err_code), 0);
    chk("reset_count", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    // Good run.
    push(1, 0, 16);
    run(-1, -1, 1'b0, -1, -1, -1, NUM_CYCLES + 1, 1'b1);

    // Stuck toggle at E4.
    push(0, 1, 2);
    run(4, -1, 1'b0, -1, -1, -1, NUM_CYCLES + 1, 1'b0);

    // Stuck toggle and bad lane on the same edge: toggle wins.
    push(0, 1, 2);
    run(4, 4, 1'b0, -1, -1, -1, NUM_CYCLES + 1, 1'b0);

    // Lane 1 mismatch at E7.
`ifdef VPI_TOGGLE_CHECKER_PIPE_EN
    push(0, 2, 5);
`else
    push(1, 0, 16);
`endif
    run(-1, 7, 1'b0, -1, -1, -1, NUM_CYCLES + 1, 1'b0);

    // Lane 0 corruption is never checked.
    push(1, 0, 16);
    run(-1, -1, 1'b1, -1, -1, -1, NUM_CYCLES + 1, 1'b0);

    // Start while busy at E5, then restart from DONE at E9.
    push(0, 3, 3);
    push(1, 0, 16);
    run(-1, -1, 1'b0, 5, 9, -1, 9 + NUM_CYCLES + 1, 1'b0);

    // Reset between E6 and E7, then a clean run.
    run(-1, -1, 1'b0, -1, -1, 6, NUM_CYCLES + 1, 1'b0);
    push(1, 0, 16);
    run(-1, -1, 1'b0, -1, -1, -1, NUM_CYCLES + 1, 1'b0);

    idle(3);
    chk("missing_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
